// File: rtl/jmp_forward_hist.sv
// Operand forwarding for the jump-target/compare path: keeps a DEPTH-entry history
// of write-backs and returns the youngest in-flight value for SEL, else the register-file read Y.
module jmp_forward_hist #(
    parameter int DATA_W = 16,
    parameter int NREG   = 4,
    parameter int SEL_W  = 3,
    parameter int DEPTH  = 2,
    parameter int CNT_W  = 16,
    localparam int AGE_W = $clog2(DEPTH + 1)
) (
    input  logic              CLK,
    input  logic              RST_N,
    input  logic              EN,
    input  logic              FLUSH,
    input  logic [DATA_W-1:0] BUS,
    input  logic [NREG-1:0]   LD,
    input  logic [SEL_W-1:0]  SEL,
    input  logic [DATA_W-1:0] Y,
    output logic [DATA_W-1:0] Y_SEL,
    output logic              HIT,
    output logic [AGE_W-1:0]  HIT_AGE,
    output logic [CNT_W-1:0]  FWD_CNT
);

    typedef struct packed {
        logic [DATA_W-1:0] data;
        logic [NREG-1:0]   ld;
    } entry_t;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    entry_t          hist [1:DEPTH];
    logic [NREG-1:0] sel_mask;

    // Register i is flagged by LD bit NREG-1-i; out-of-range selectors get an empty mask.
    always_comb begin
        sel_mask = '0;
        if (int'(SEL) < NREG) begin
            sel_mask = NREG'(1) << (NREG - 1 - int'(SEL));
        end
    end

    // NOTE: every output gets a default before any conditional assignment, so no latch is inferred.
    always_comb begin
        Y_SEL   = Y;
        HIT     = 1'b0;
        HIT_AGE = '0;
        if (|(LD & sel_mask)) begin
            Y_SEL = BUS;
            HIT   = 1'b1;
        end else begin
            // Scan oldest to youngest so the youngest matching entry is the last writer.
            for (int k = DEPTH; k >= 1; k--) begin
                if (|(hist[k].ld & sel_mask)) begin
                    Y_SEL   = hist[k].data;
                    HIT     = 1'b1;
                    HIT_AGE = AGE_W'(k);
                end
            end
        end
    end

    // NOTE: the history is a handful of flops, not a RAM, so it is reset like any other state.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            for (int k = 1; k <= DEPTH; k++) begin
                hist[k] <= '0;
            end
        end else if (FLUSH) begin
            for (int k = 1; k <= DEPTH; k++) begin
                hist[k].ld <= '0;
            end
        end else if (EN) begin
            // NOTE: non-blocking assignments let every entry shift from its pre-edge neighbour.
            hist[1] <= '{data: BUS, ld: LD};
            for (int k = 2; k <= DEPTH; k++) begin
                hist[k] <= hist[k-1];
            end
        end
    end

    // Hit statistics: only cycles that actually advance the pipeline are counted.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            FWD_CNT <= '0;
        end else if (HIT && EN && !FLUSH && (FWD_CNT != CNT_MAX)) begin
            FWD_CNT <= FWD_CNT + 1'b1;
        end
    end

endmodule

// File: tb/tb_jmp_forward_hist.sv
// Directed bench for jmp_forward_hist: live/history priority, stall, flush, selector range,
// multi-register writes and counter saturation (via a second instance with a 4-bit counter).
module tb_jmp_forward_hist;

    logic        CLK = 1'b0;
    logic        RST_N;
    logic        EN;
    logic        FLUSH;
    logic [15:0] BUS;
    logic [3:0]  LD;
    logic [2:0]  SEL;
    logic [15:0] Y;

    logic [15:0] y_sel;
    logic        hit;
    logic [1:0]  hit_age;
    logic [15:0] fwd_cnt;

    logic [15:0] y_sel_s;
    logic        hit_s;
    logic [1:0]  hit_age_s;
    logic [3:0]  fwd_cnt_s;

    int vectors = 0;
    int miscompares = 0;

    always #5 CLK = ~CLK;

    jmp_forward_hist dut (
        .CLK(CLK), .RST_N(RST_N), .EN(EN), .FLUSH(FLUSH), .BUS(BUS), .LD(LD),
        .SEL(SEL), .Y(Y), .Y_SEL(y_sel), .HIT(hit), .HIT_AGE(hit_age), .FWD_CNT(fwd_cnt)
    );

    jmp_forward_hist #(.CNT_W(4)) dut_sat (
        .CLK(CLK), .RST_N(RST_N), .EN(EN), .FLUSH(FLUSH), .BUS(BUS), .LD(LD),
        .SEL(SEL), .Y(Y), .Y_SEL(y_sel_s), .HIT(hit_s), .HIT_AGE(hit_age_s), .FWD_CNT(fwd_cnt_s)
    );

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        vectors++;
        assert (observed === expected)
        else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    task automatic fwd(input string tag, input logic [15:0] val, input logic h, input logic [1:0] age);
        #1;
        check({tag, ".y_sel"}, 32'(y_sel), 32'(val));
        check({tag, ".hit"}, 32'(hit), 32'(h));
        check({tag, ".age"}, 32'(hit_age), 32'(age));
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    initial begin
        RST_N = 1'b0; EN = 1'b0; FLUSH = 1'b0;
        BUS = 16'h0000; LD = 4'b0000; SEL = 3'd1; Y = 16'h1111;

        // Reset state: pure pass-through, counters clear
        fwd("reset", 16'h1111, 1'b0, 2'd0);
        check("reset.cnt", 32'(fwd_cnt), 32'd0);
        check("reset.cnt_s", 32'(fwd_cnt_s), 32'd0);

        // Live forward works even in reset; edges in reset store nothing
        LD = 4'b0100; BUS = 16'hABCD; Y = 16'h0000;
        fwd("live", 16'hABCD, 1'b1, 2'd0);
        EN = 1'b1;
        step();
        LD = 4'b0000;
        fwd("reset_hold", 16'h0000, 1'b0, 2'd0);
        check("reset_hold.cnt", 32'(fwd_cnt), 32'd0);
        RST_N = 1'b1;

        // Age order: two writes to reg3, then let them age out
        SEL = 3'd3; Y = 16'h1234;
        LD = 4'b0001; BUS = 16'h0005;
        step();
        LD = 4'b0001; BUS = 16'h0006;
        step();
        LD = 4'b0000; BUS = 16'hFFFF;
        fwd("age1", 16'h0006, 1'b1, 2'd1);
        step();
        fwd("age2", 16'h0006, 1'b1, 2'd2);
        step();
        fwd("aged_out", 16'h1234, 1'b0, 2'd0);
        check("age.cnt", 32'(fwd_cnt), 32'd4);

        // Stall: entry held at age 1, counter frozen
        SEL = 3'd0; LD = 4'b1000; BUS = 16'h00F0;
        step();
        LD = 4'b0000; EN = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step();
            fwd("stall", 16'h00F0, 1'b1, 2'd1);
        end
        check("stall.cnt", 32'(fwd_cnt), 32'd5);

        // Flush overrides EN; live path still forwards in the flush cycle
        EN = 1'b1; SEL = 3'd2; Y = 16'h2222; LD = 4'b0010; BUS = 16'h3333;
        step();
        LD = 4'b0000;
        fwd("pre_flush", 16'h3333, 1'b1, 2'd1);
        FLUSH = 1'b1; LD = 4'b0010; BUS = 16'h7777;
        fwd("flush_live", 16'h7777, 1'b1, 2'd0);
        step();
        FLUSH = 1'b0; LD = 4'b0000;
        fwd("post_flush", 16'h2222, 1'b0, 2'd0);
        check("flush.cnt", 32'(fwd_cnt), 32'd6);

        // Live BUS has priority over an older history entry
        SEL = 3'd3; Y = 16'h4444; LD = 4'b0001; BUS = 16'h0AAA;
        step();
        BUS = 16'h0BBB;
        fwd("bus_prio", 16'h0BBB, 1'b1, 2'd0);
        step();
        LD = 4'b0000;
        fwd("young_hist", 16'h0BBB, 1'b1, 2'd1);
        step();
        step();
        fwd("drained", 16'h4444, 1'b0, 2'd0);
        check("prio.cnt", 32'(fwd_cnt), 32'd10);

        // Selector out of range never matches
        EN = 1'b0; Y = 16'h5555; LD = 4'b1111; BUS = 16'h9999;
        SEL = 3'd5;
        fwd("sel5", 16'h5555, 1'b0, 2'd0);
        SEL = 3'd4;
        fwd("sel4", 16'h5555, 1'b0, 2'd0);

        // Multi-register write
        LD = 4'b1010; BUS = 16'h0042;
        SEL = 3'd0;
        fwd("multi_r0", 16'h0042, 1'b1, 2'd0);
        SEL = 3'd2;
        fwd("multi_r2", 16'h0042, 1'b1, 2'd0);
        SEL = 3'd1;
        fwd("multi_r1", 16'h5555, 1'b0, 2'd0);

        // Saturation: 20 more hit cycles
        EN = 1'b1; LD = 4'b1000; SEL = 3'd0; BUS = 16'h0001;
        for (int i = 0; i < 20; i++) begin
            step();
        end
        check("sat.cnt16", 32'(fwd_cnt), 32'd30);
        check("sat.cnt4", 32'(fwd_cnt_s), 32'hF);

        // Asynchronous reset mid-operation clears history and counters at once
        LD = 4'b0000; Y = 16'h6666;
        fwd("pre_rst", 16'h0001, 1'b1, 2'd1);
        RST_N = 1'b0;
        fwd("async_rst", 16'h6666, 1'b0, 2'd0);
        check("async_rst.cnt", 32'(fwd_cnt), 32'd0);
        check("async_rst.cnt_s", 32'(fwd_cnt_s), 32'd0);
        RST_N = 1'b1;

        // First edge after release behaves normally
        LD = 4'b1000; BUS = 16'h0123;
        step();
        LD = 4'b0000;
        fwd("post_rst", 16'h0123, 1'b1, 2'd1);
        check("post_rst.cnt", 32'(fwd_cnt), 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
